seq_mult_ctrl: RTL and testbench
================================

# seq_mult_ctrl

Sequencing controller for a shared shift-add multiplier datapath. It accepts an operand pair over a valid/ready handshake, latches the operands into internal registers, and runs N add-shift iterations on a single adder. It then holds the 2N-bit unsigned product on a valid/ready output until the consumer takes it. It sits between the operand-producing registers and the product register stage in the multiplier subsystem, and replaces per-register read/write-enable strobing with one handshaked request/response.

## Interface
- N, default 32: operand width in bits; legal N ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start_valid  in  1  the operand pair on a_in/b_in is valid.
- start_ready  out  1  the controller can accept an operand pair.
- a_in  in  N  multiplicand, unsigned.
- b_in  in  N  multiplier, unsigned.
- result_valid  out  1  product holds a finished result.
- result_ready  in  1  the consumer accepts the product.
- product  out  2N  unsigned product a×b.
- busy  out  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - start_ready = 1.
  - On an edge with start_valid && start_ready:
    - latch A ← a_in.
    - load the accumulator P[2N:0] ← {(N+1)'b0, b_in}.
    - count ← 0.
    - go to RUN.
- RUN
  - Each edge does one iteration:
    - if P[0] = 1, P[2N:N] ← P[2N-1:N] + A, with the carry kept in bit 2N.
    - then P ← P >> 1.
    - count ← count + 1.
  - When count = N−1 on an edge, that edge completes the last iteration and the state goes to DONE.
- DONE
  - result_valid = 1.
  - product = P[2N-1:0], held stable while result_valid = 1.
  - On an edge with result_ready = 1, go to IDLE.
- start_ready = 1 only in IDLE. start_valid in RUN or DONE is ignored and does not stall or corrupt the operation in flight.
- product is driven from P in every state. It is defined only when result_valid = 1.
- Arithmetic is unsigned. Bit 2N of P absorbs the adder carry, so there is no overflow. The full product 2^2N − 2^(N+1) + 1 for all-ones operands is exact.
- a_in and b_in are sampled only on the accept edge. Later changes to them have no effect.
- Reset:
  - state → IDLE.
  - P, A and count → 0.
  - Outputs: start_ready = 1, result_valid = 0, busy = 0, product = 0.
  - Reset has priority over every handshake. Reset in RUN or DONE aborts the operation and discards the result.

## Timing
- Accept edge t0 (start_valid && start_ready): start_ready drops to 0 and busy rises to 1 in the following cycle.
- Iterations run on edges t0+1 … t0+N.
- result_valid = 1 from the cycle after edge t0+N. Latency from acceptance to result_valid is N+1 cycles.
- result_ready = 1 in the first DONE cycle: DONE lasts exactly one cycle, and start_ready = 1 again in the cycle after the following edge.
- Minimum issue interval: N+2 cycles.
- result_ready while result_valid = 0 has no effect.
- If result_ready and start_valid are both high in DONE, only the result handshake completes. The new operand pair is accepted no earlier than the next IDLE cycle.

## Structure
- Shared package mult_pkg holds:
  - the state typedef (IDLE, RUN, DONE).
  - a count-width function, $clog2(N).
- One sub-module: seq_mult_datapath. It contains the A register, the P accumulator, the adder and the shifter, controlled by load and step strobes.
- seq_mult_ctrl contains the FSM, the counter, the handshake logic and one seq_mult_datapath instance.

## Test plan
- N=8, accept a=13, b=11 at t0 with result_ready=1 → result_valid=1 in the cycle after edge t0+8, product=143, start_ready=1 again in the cycle after edge t0+9.
- N=8, a=255, b=255 → product=65025; a=0, b=200 → product=0; a=1, b=1 → product=1.
- N=8, a=7, b=9, result_ready held 0 for 5 DONE cycles → product=63 stable and result_valid=1 throughout, start_ready=0 throughout; after the release edge start_ready=1.
- N=8, accept a=20, b=3, then hold start_valid=1 with a_in=99, b_in=99 during RUN → product=60, and only one result is produced before returning to IDLE.
- N=8, assert reset in RUN iteration 4 → next cycle state IDLE, result_valid=0, busy=0, product=0; a fresh request a=5, b=6 then yields product=30.
- N=32, a=0xFFFFFFFF, b=0xFFFFFFFF → product=0xFFFFFFFE00000001 in the cycle after edge t0+32.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Iteration counter width; counts 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: multiplicand register, accumulator, single adder, shifter.
module seq_mult_datapath #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic [2*N-1:0] product
);

  logic [N-1:0]   a_reg;
  logic [2*N-1:0] acc;
  logic [N:0]     sum;

  // The adder carry lands in the top bit of the shifted accumulator, so the
  // always-zero bit above it never needs to be stored.
  always_comb begin
    sum = {1'b0, acc[2*N-1:N]};
    if (acc[0]) sum = {1'b0, acc[2*N-1:N]} + {1'b0, a_reg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      acc   <= '0;
    end else if (load) begin
      a_reg <= a_in;
      acc   <= {{N{1'b0}}, b_in};
    end else if (step) begin
      acc   <= {sum, acc[N-1:1]};
    end
  end

  assign product = acc;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Handshaked sequencing controller around a shared shift-add multiplier datapath.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           result_valid,
  input  logic           result_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          accept;
  logic          step;

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign accept       = start_valid && start_ready;
  assign step         = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= RUN;
          count <= '0;
        end
        RUN: begin
          count <= count + CW'(1);
          if (count == LAST) state <= DONE;
        end
        DONE: if (result_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  seq_mult_datapath #(.N(N)) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .step    (step),
    .a_in    (a_in),
    .b_in    (b_in),
    .product (product)
  );

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed-vector bench for seq_mult_ctrl at N=8 and N=32.
module tb_seq_mult_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic        rst8, sv8, sr8, rv8, rr8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  // N=32 instance
  logic        rst32, sv32, sr32, rv32, rr32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  seq_mult_ctrl #(.N(8)) dut8 (
    .clk(clk), .reset(rst8), .start_valid(sv8), .start_ready(sr8),
    .a_in(a8), .b_in(b8), .result_valid(rv8), .result_ready(rr8),
    .product(p8), .busy(busy8)
  );

  seq_mult_ctrl #(.N(32)) dut32 (
    .clk(clk), .reset(rst32), .start_valid(sv32), .start_ready(sr32),
    .a_in(a32), .b_in(b32), .result_valid(rv32), .result_ready(rr32),
    .product(p32), .busy(busy32)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full N=8 transaction with result_ready held high.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    sv8 = 1'b1; a8 = a; b8 = b; rr8 = 1'b1;
    tick();                                  // accept edge t0
    sv8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx;
    check({tag, ".busy"}, 64'(busy8), 64'd1);
    check({tag, ".sr_low"}, 64'(sr8), 64'd0);
    repeat (7) tick();                       // edges t0+1..t0+7
    check({tag, ".rv_early"}, 64'(rv8), 64'd0);
    tick();                                  // edge t0+8
    check({tag, ".rv"}, 64'(rv8), 64'd1);
    check({tag, ".prod"}, 64'(p8), 64'(exp));
    tick();                                  // edge t0+9
    check({tag, ".sr_back"}, 64'(sr8), 64'd1);
    check({tag, ".rv_clr"}, 64'(rv8), 64'd0);
  endtask

  initial begin
    rst8 = 1'b1; sv8 = 1'b0; rr8 = 1'b0; a8 = '0; b8 = '0;
    rst32 = 1'b1; sv32 = 1'b0; rr32 = 1'b0; a32 = '0; b32 = '0;
    #1;
    tick(); tick();
    check("rst.sr",   64'(sr8),   64'd1);
    check("rst.rv",   64'(rv8),   64'd0);
    check("rst.busy", 64'(busy8), 64'd0);
    check("rst.prod", 64'(p8),    64'd0);
    check("rst32.prod", p32,      64'd0);
    rst8 = 1'b0; rst32 = 1'b0;
    tick();

    op8("m13x11", 8'd13,  8'd11,  16'd143);
    op8("m255sq", 8'd255, 8'd255, 16'd65025);
    op8("m0x200", 8'd0,   8'd200, 16'd0);
    op8("m1x1",   8'd1,   8'd1,   16'd1);

    // Consumer stalls for 5 DONE cycles.
    sv8 = 1'b1; a8 = 8'd7; b8 = 8'd9; rr8 = 1'b0;
    tick();
    sv8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      check("hold.rv",   64'(rv8), 64'd1);
      check("hold.prod", 64'(p8),  64'd63);
      check("hold.sr",   64'(sr8), 64'd0);
      if (i < 4) tick();
    end
    rr8 = 1'b1;
    tick();
    check("hold.release", 64'(sr8), 64'd1);

    // Operands offered during RUN and DONE are ignored.
    sv8 = 1'b1; a8 = 8'd20; b8 = 8'd3;
    tick();
    a8 = 8'd99; b8 = 8'd99;
    repeat (8) tick();
    check("ign.rv",   64'(rv8), 64'd1);
    check("ign.prod", 64'(p8),  64'd60);
    tick();
    check("ign.idle", 64'(sr8), 64'd1);
    check("ign.one",  64'(rv8), 64'd0);
    sv8 = 1'b0;
    tick();
    check("ign.noacc", 64'(busy8), 64'd0);

    // Reset during RUN iteration 4 aborts the operation.
    sv8 = 1'b1; a8 = 8'd77; b8 = 8'd55;
    tick();
    sv8 = 1'b0;
    repeat (3) tick();
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    check("abort.sr",   64'(sr8),   64'd1);
    check("abort.rv",   64'(rv8),   64'd0);
    check("abort.busy", 64'(busy8), 64'd0);
    check("abort.prod", 64'(p8),    64'd0);
    op8("m5x6", 8'd5, 8'd6, 16'd30);

    // N=32 all-ones.
    sv32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; rr32 = 1'b1;
    tick();
    sv32 = 1'b0;
    repeat (31) tick();
    check("w32.rv_early", 64'(rv32), 64'd0);
    tick();
    check("w32.rv",   64'(rv32), 64'd1);
    check("w32.prod", p32,       64'hFFFF_FFFE_0000_0001);
    tick();
    check("w32.sr",   64'(sr32), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
